// File: rtl/tag_free_list_mp.sv
`default_nettype none
// ============================================================================
// Module   : tag_free_list_mp
// Function : show-ahead circular free list of rename tags, 1 pop / 2 returns
// Revision : 1.0
// ============================================================================
module tag_free_list_mp #(
  parameter int TAG_WIDTH = 6,
  parameter int DEPTH     = 64,
  parameter int AE_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ren_tf,
  output logic [TAG_WIDTH-1:0]       tagout_tf,
  output logic                       ef_tf,
  output logic                       ff_tf,
  output logic                       aef_tf,
  output logic [$clog2(DEPTH):0]     count_tf,
  input  logic [TAG_WIDTH-1:0]       cdb_tag0_tf,
  input  logic                       cdb_tag0_tf_valid,
  input  logic [TAG_WIDTH-1:0]       cdb_tag1_tf,
  input  logic                       cdb_tag1_tf_valid,
  output logic                       err_tf
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]    C_AE    = AE_THRESH;

  logic [TAG_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]       r_rp;
  logic [PTR_W:0]       r_wp;
  logic                 r_err;

  logic [PTR_W:0]       w_count;
  logic [31:0]          w_count32;
  logic                 w_empty;
  logic                 w_pop;
  logic [PTR_W:0]       w_space;
  logic                 w_g0;
  logic                 w_g1;
  logic [PTR_W:0]       w_nwr;
  logic [PTR_W-1:0]     w_widx0;
  logic [PTR_W-1:0]     w_widx1;
  logic                 w_err_evt;

  assign w_count   = r_wp - r_rp;
  assign w_count32 = {{(31-PTR_W){1'b0}}, w_count};
  assign w_empty   = (r_wp == r_rp);

  assign count_tf  = w_count;
  assign ef_tf     = w_empty;
  assign ff_tf     = (r_wp[PTR_W-1:0] == r_rp[PTR_W-1:0]) && (r_wp[PTR_W] != r_rp[PTR_W]);
  assign aef_tf    = (w_count32 <= C_AE);
  assign tagout_tf = r_mem[r_rp[PTR_W-1:0]];
  assign err_tf    = r_err;

  // A pop in the same cycle frees one slot for the returning tags.
  assign w_pop   = ren_tf && !w_empty;
  assign w_space = C_DEPTH - w_count + {{PTR_W{1'b0}}, w_pop};

  assign w_g0    = cdb_tag0_tf_valid && (w_space != '0);
  assign w_g1    = cdb_tag1_tf_valid && (w_space > {{PTR_W{1'b0}}, w_g0});
  assign w_nwr   = {{PTR_W{1'b0}}, w_g0} + {{PTR_W{1'b0}}, w_g1};

  assign w_widx0 = r_wp[PTR_W-1:0];
  assign w_widx1 = r_wp[PTR_W-1:0] + {{(PTR_W-1){1'b0}}, w_g0};

  assign w_err_evt = (ren_tf && w_empty)
                   || (cdb_tag0_tf_valid && !w_g0)
                   || (cdb_tag1_tf_valid && !w_g1);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_WIDTH'(i);
      end
      r_rp  <= '0;
      r_wp  <= C_DEPTH;
      r_err <= 1'b0;
    end else begin
      if (w_g0) r_mem[w_widx0] <= cdb_tag0_tf;
      if (w_g1) r_mem[w_widx1] <= cdb_tag1_tf;
      r_rp <= r_rp + {{PTR_W{1'b0}}, w_pop};
      r_wp <= r_wp + w_nwr;
      if (w_err_evt) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_free_list_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_free_list_mp
// Function : scoreboard bench for tag_free_list_mp against a queue model
// Revision : 1.0
// ============================================================================
module tb_tag_free_list_mp;

  localparam int TAG_WIDTH = 6;
  localparam int DEPTH     = 64;
  localparam int AE_THRESH = 4;
  localparam int PTR_W     = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush = 1'b0;
  logic                 ren_tf = 1'b0;
  logic [TAG_WIDTH-1:0] tagout_tf;
  logic                 ef_tf, ff_tf, aef_tf, err_tf;
  logic [PTR_W:0]       count_tf;
  logic [TAG_WIDTH-1:0] cdb_tag0_tf = '0;
  logic                 cdb_tag0_tf_valid = 1'b0;
  logic [TAG_WIDTH-1:0] cdb_tag1_tf = '0;
  logic                 cdb_tag1_tf_valid = 1'b0;

  tag_free_list_mp #(
    .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH), .AE_THRESH(AE_THRESH)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .ren_tf(ren_tf),
    .tagout_tf(tagout_tf), .ef_tf(ef_tf), .ff_tf(ff_tf), .aef_tf(aef_tf),
    .count_tf(count_tf),
    .cdb_tag0_tf(cdb_tag0_tf), .cdb_tag0_tf_valid(cdb_tag0_tf_valid),
    .cdb_tag1_tf(cdb_tag1_tf), .cdb_tag1_tf_valid(cdb_tag1_tf_valid),
    .err_tf(err_tf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit ef;
    bit ff;
    bit aef;
    bit err;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  bit   model_err;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Free list as a plain FIFO of tag values; sequencing of pop and returns follows the rules directly.
  task automatic model_step(input bit rst, input bit fl, input bit ren,
                            input bit v0, input int t0, input bit v1, input int t1);
    int space;
    bit pop;
    if (rst || fl) begin
      model_q.delete();
      for (int i = 0; i < DEPTH; i++) model_q.push_back(i);
      model_err = 1'b0;
    end else begin
      pop   = ren && (model_q.size() > 0);
      if (ren && !pop) model_err = 1'b1;
      space = DEPTH - model_q.size() + (pop ? 1 : 0);
      if (pop) void'(model_q.pop_front());
      if (v0) begin
        if (space >= 1) begin model_q.push_back(t0); space--; end
        else model_err = 1'b1;
      end
      if (v1) begin
        if (space >= 1) begin model_q.push_back(t1); space--; end
        else model_err = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit fl, input bit ren,
                     input bit v0, input int t0, input bit v1, input int t1);
    exp_t e;
    reset = rst; flush = fl; ren_tf = ren;
    cdb_tag0_tf_valid = v0; cdb_tag0_tf = TAG_WIDTH'(t0);
    cdb_tag1_tf_valid = v1; cdb_tag1_tf = TAG_WIDTH'(t1);
    @(posedge clk);
    #1;
    model_step(rst, fl, ren, v0, t0, v1, t1);
    e.count = model_q.size();
    e.ef    = (model_q.size() == 0);
    e.ff    = (model_q.size() == DEPTH);
    e.aef   = (model_q.size() <= AE_THRESH);
    e.err   = model_err;
    e.tag   = (model_q.size() > 0) ? model_q[0] : 0;
    exp_q.push_back(e);
    reset = 1'b0; flush = 1'b0; ren_tf = 1'b0;
    cdb_tag0_tf_valid = 1'b0; cdb_tag1_tf_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", int'(count_tf), e.count);
      chk("ef",    int'(ef_tf),    int'(e.ef));
      chk("ff",    int'(ff_tf),    int'(e.ff));
      chk("aef",   int'(aef_tf),   int'(e.aef));
      chk("err",   int'(err_tf),   int'(e.err));
      if (!e.ef) chk("tagout", int'(tagout_tf), e.tag);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Drain all 64 tags in order, then one pop too many.
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Dual return into the empty list, then single port-1 return.
    cyc(0, 0, 0, 1, 'h2A, 1, 'h15);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 'h07);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Overflow arbitration at count 63, then with a concurrent pop.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h11, 1, 'h22);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 'h11, 1, 'h22);
    cyc(0, 0, 1, 1, 'h33, 1, 'h34);

    // Random pop/return traffic across several pointer wraps.
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 63)));
    end

    // Flush mid-stream with pop and both writes in the same cycle.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < DEPTH - 10; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 'h3F, 1, 'h3E);
    cyc(0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
